id_stage_branch: RTL and testbench

- Decode stage directly downstream of the branch-capable fetch stage.
- Consumes the 32-bit instruction word from the synchronous-read instruction memory and reads a 32-entry register file.
- Resolves branches and drives `branch_target` / `br1` back to fetch; suppresses stale and wrong-path fetch slots.
- Registers decoded fields and operands into the ID/EX pipeline register.

---
 rtl/id_stage_branch_if.sv | 36 +++
 rtl/id_stage_branch.sv | 160 ++++++++++++++++
 tb/tb_id_stage_branch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_branch_if.sv
// Fetch/writeback <-> decode bundle for id_stage_branch.
// master = fetch/writeback/EX side, slave = the decode stage itself.
interface id_stage_branch_if #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 9
);
    logic [31:0]       instr;
    logic              br1;
    logic [PC_W-1:0]   branch_target;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic [5:0]        ex_opcode;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_rs1_data;
    logic [DATA_W-1:0] ex_rs2_data;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_reg_we;
    logic              ex_mem_re;
    logic              ex_mem_we;

    modport master (
        output instr, wb_en, wb_addr, wb_data,
        input  br1, branch_target,
        input  ex_valid, ex_opcode, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_reg_we, ex_mem_re, ex_mem_we
    );

    modport slave (
        input  instr, wb_en, wb_addr, wb_data,
        output br1, branch_target,
        output ex_valid, ex_opcode, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_reg_we, ex_mem_re, ex_mem_we
    );
endinterface

// File: rtl/id_stage_branch.sv
// Decode stage with branch resolution, 32-entry register file and ID/EX register.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data to register reads.
module id_stage_branch #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    id_stage_branch_if.slave  bus
);
    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_LOAD  = 6'h20;
    localparam logic [5:0] OP_STORE = 6'h21;
    localparam logic [5:0] OP_J     = 6'h10;
    localparam logic [5:0] OP_BEQ   = 6'h11;
    localparam logic [5:0] OP_BNE   = 6'h12;

    typedef enum logic [1:0] {
        WARM   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] rf [32];

    logic [5:0]        opcode;
    logic [4:0]        rd_idx;
    logic [4:0]        rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [DATA_W-1:0] imm_sext;
    logic              operands_eq;
    logic              is_j, is_beq, is_bne;
    logic              dec_reg_we, dec_mem_re, dec_mem_we;
    logic              br1;

    logic              ex_valid_q, ex_valid_d;
    logic [5:0]        ex_opcode_q, ex_opcode_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [DATA_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic              ex_reg_we_q, ex_reg_we_d;
    logic              ex_mem_re_q, ex_mem_re_d;
    logic              ex_mem_we_q, ex_mem_we_d;

    assign opcode     = bus.instr[31:26];
    assign rd_idx     = bus.instr[25:21];
    assign rd_addr[0] = bus.instr[20:16];
    assign rd_addr[1] = bus.instr[15:11];
    assign imm_sext   = {{(DATA_W-16){bus.instr[15]}}, bus.instr[15:0]};

    // Register file contents are intentionally not reset; r0 is forced to zero on read.
    always_ff @(posedge clk) begin
        if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef WB_BYPASS_EN
            assign rd_data[gi] = (rd_addr[gi] == 5'd0) ? '0 :
                                 (bus.wb_en && (bus.wb_addr == rd_addr[gi])) ? bus.wb_data :
                                 rf[rd_addr[gi]];
`else
            assign rd_data[gi] = (rd_addr[gi] == 5'd0) ? '0 : rf[rd_addr[gi]];
`endif
        end
    endgenerate

    always_comb begin
        is_j        = (opcode == OP_J);
        is_beq      = (opcode == OP_BEQ);
        is_bne      = (opcode == OP_BNE);
        dec_reg_we  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_LOAD);
        dec_mem_re  = (opcode == OP_LOAD);
        dec_mem_we  = (opcode == OP_STORE);
        operands_eq = (rd_data[0] == rd_data[1]);
    end

    // Only a live RUN slot may redirect fetch; WARM/SQUASH words are stale.
    assign br1 = !rst && (state_q == RUN) &&
                 (is_j || (is_beq && operands_eq) || (is_bne && !operands_eq));

    assign bus.br1           = br1;
    assign bus.branch_target = bus.instr[PC_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            WARM:    state_d = RUN;
            RUN:     state_d = br1 ? SQUASH : RUN;
            SQUASH:  state_d = RUN;
            default: state_d = WARM;
        endcase
    end

    always_comb begin
        ex_valid_d  = 1'b0;
        ex_opcode_d = '0;
        ex_rd_d     = '0;
        ex_rs1_d    = '0;
        ex_rs2_d    = '0;
        ex_imm_d    = '0;
        ex_reg_we_d = 1'b0;
        ex_mem_re_d = 1'b0;
        ex_mem_we_d = 1'b0;
        if (state_q == RUN) begin
            ex_valid_d  = 1'b1;
            ex_opcode_d = opcode;
            ex_rd_d     = rd_idx;
            ex_rs1_d    = rd_data[0];
            ex_rs2_d    = rd_data[1];
            ex_imm_d    = imm_sext;
            ex_reg_we_d = dec_reg_we;
            ex_mem_re_d = dec_mem_re;
            ex_mem_we_d = dec_mem_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WARM;
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_imm_q    <= '0;
            ex_reg_we_q <= 1'b0;
            ex_mem_re_q <= 1'b0;
            ex_mem_we_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_opcode_q <= ex_opcode_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_imm_q    <= ex_imm_d;
            ex_reg_we_q <= ex_reg_we_d;
            ex_mem_re_q <= ex_mem_re_d;
            ex_mem_we_q <= ex_mem_we_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_opcode   = ex_opcode_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_rs1_data = ex_rs1_q;
    assign bus.ex_rs2_data = ex_rs2_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_reg_we   = ex_reg_we_q;
    assign bus.ex_mem_re   = ex_mem_re_q;
    assign bus.ex_mem_we   = ex_mem_we_q;
endmodule

// File: tb/tb_id_stage_branch.sv
// Randomised and directed bench for id_stage_branch against a slot-skip reference model.
module tb_id_stage_branch;
    localparam int DW = 64;
    localparam int PW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_branch_if #(.DATA_W(DW), .PC_W(PW)) bus ();

    id_stage_branch #(.DATA_W(DW), .PC_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: register contents plus number of fetch slots still to discard.
    logic [63:0] m_rf [32];
    int          m_skip = 1;
    logic        exp_br;
    logic [8:0]  exp_tgt;
    logic        e_valid, e_we, e_re, e_mwe;
    logic [5:0]  e_op;
    logic [4:0]  e_rd;
    logic [63:0] e_rs1, e_rs2, e_imm;

    function automatic logic [63:0] m_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wa, input logic [63:0] wd);
        if (r == 5'd0) return 64'd0;
`ifdef WB_BYPASS_EN
        if (we && wa == r) return wd;
`endif
        return m_rf[r];
    endfunction

    function automatic logic [206:0] exp_ex();
        return {e_valid, e_op, e_rd, e_rs1, e_rs2, e_imm, e_we, e_re, e_mwe};
    endfunction

    function automatic logic [206:0] dut_ex();
        return {bus.ex_valid, bus.ex_opcode, bus.ex_rd, bus.ex_rs1_data, bus.ex_rs2_data,
                bus.ex_imm, bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we};
    endfunction

    // Drives one cycle of inputs at the falling edge and advances the model for that cycle.
    task automatic apply(input logic r, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [63:0] wd);
        logic [63:0] va, vb;
        logic [5:0]  op;
        logic        live, taken;
        @(negedge clk);
        rst         = r;
        bus.instr   = ins;
        bus.wb_en   = we;
        bus.wb_addr = wa;
        bus.wb_data = wd;
        op    = ins[31:26];
        va    = m_read(ins[20:16], we, wa, wd);
        vb    = m_read(ins[15:11], we, wa, wd);
        live  = !r && (m_skip == 0);
        taken = live && (op == 6'h10 || (op == 6'h11 && va == vb) || (op == 6'h12 && va != vb));
        exp_br  = taken;
        exp_tgt = ins[8:0];
        if (live) begin
            e_valid = 1'b1; e_op = op; e_rd = ins[25:21]; e_rs1 = va; e_rs2 = vb;
            e_imm   = {{48{ins[15]}}, ins[15:0]};
            e_we    = (op == 6'h01 || op == 6'h02 || op == 6'h20);
            e_re    = (op == 6'h20);
            e_mwe   = (op == 6'h21);
            m_skip  = taken ? 1 : 0;
        end else begin
            e_valid = 1'b0; e_op = '0; e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0;
            e_we = 1'b0; e_re = 1'b0; e_mwe = 1'b0;
            m_skip = r ? 1 : 0;
        end
        if (we && wa != 5'd0) m_rf[wa] = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1'b1, 32'h04221000, 1'b0, 5'd0, 64'd0);
        tick();
        apply(1'b1, 32'h04221000, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b0) begin
            errors++; $display("FAIL reset_br1 got=%0b want=0", bus.br1);
        end
        tick();
        checks++;
        if (dut_ex() !== '0) begin
            errors++; $display("FAIL reset_ex got=%h want=0", dut_ex());
        end
        apply(1'b0, 32'h04221000, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b0) begin
            errors++; $display("FAIL warm_br1 got=%0b want=0", bus.br1);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0) begin
            errors++; $display("FAIL warm_discard valid=%0b we=%0b want 0/0", bus.ex_valid, bus.ex_reg_we);
        end
        apply(1'b0, 32'h04221000, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b0) begin
            errors++; $display("FAIL run_br1 got=%0b want=0", bus.br1);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== 6'h01 || bus.ex_rd !== 5'd1 || bus.ex_reg_we !== 1'b1) begin
            errors++; $display("FAIL first_decode valid=%0b op=%h rd=%0d we=%0b want 1/01/1/1",
                               bus.ex_valid, bus.ex_opcode, bus.ex_rd, bus.ex_reg_we);
        end
    endtask

    task automatic test_fill();
        for (int r = 1; r < 32; r++) begin
            apply(1'b0, 32'h0, 1'b1, 5'(r), {$urandom, $urandom});
            tick();
            checks++;
            if (dut_ex() !== exp_ex()) begin
                errors++; $display("FAIL fill_nop r=%0d got=%h want=%h", r, dut_ex(), exp_ex());
            end
        end
        apply(1'b0, 32'h0, 1'b1, 5'd3, 64'd5);
        tick();
        apply(1'b0, 32'h0, 1'b1, 5'd4, 64'd5);
        tick();
    endtask

    task automatic test_branch();
        apply(1'b0, {6'h11, 5'd0, 5'd3, 5'd4, 11'h1A0}, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b1 || bus.branch_target !== 9'h1A0) begin
            errors++; $display("FAIL beq_taken br1=%0b tgt=%h want 1/1a0", bus.br1, bus.branch_target);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_reg_we !== 1'b0 || bus.ex_mem_re !== 1'b0 || bus.ex_mem_we !== 1'b0) begin
            errors++; $display("FAIL beq_idex valid=%0b we=%0b re=%0b mwe=%0b want 1/0/0/0",
                               bus.ex_valid, bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we);
        end
        apply(1'b0, {6'h10, 26'h00000AB}, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b0) begin
            errors++; $display("FAIL squash_j_br1 got=%0b want=0", bus.br1);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0 || bus.ex_mem_re !== 1'b0 || bus.ex_mem_we !== 1'b0) begin
            errors++; $display("FAIL squash_slot valid=%0b want=0", bus.ex_valid);
        end
        apply(1'b0, {6'h01, 5'd2, 5'd3, 5'd4, 11'd0}, 1'b0, 5'd0, 64'd0);
        tick();
        checks++;
        if (dut_ex() !== exp_ex() || bus.ex_rs1_data !== 64'd5) begin
            errors++; $display("FAIL resume_decode got=%h want=%h", dut_ex(), exp_ex());
        end
        apply(1'b0, 32'h0, 1'b1, 5'd4, 64'd6);
        tick();
        apply(1'b0, {6'h11, 5'd0, 5'd3, 5'd4, 11'h055}, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b0) begin
            errors++; $display("FAIL beq_not_taken br1=%0b want=0", bus.br1);
        end
        tick();
        apply(1'b0, {6'h12, 5'd0, 5'd3, 5'd4, 11'h0C3}, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b1 || bus.branch_target !== 9'h0C3) begin
            errors++; $display("FAIL bne_taken br1=%0b tgt=%h want 1/0c3", bus.br1, bus.branch_target);
        end
        tick();
        apply(1'b0, 32'h0, 1'b0, 5'd0, 64'd0);
        tick();
    endtask

    task automatic test_load();
        apply(1'b0, {6'h20, 5'd7, 5'd1, 16'hFFF0}, 1'b0, 5'd0, 64'd0);
        tick();
        checks++;
        if (bus.ex_mem_re !== 1'b1 || bus.ex_reg_we !== 1'b1 || bus.ex_mem_we !== 1'b0 ||
            bus.ex_rd !== 5'd7 || bus.ex_imm !== 64'hFFFF_FFFF_FFFF_FFF0) begin
            errors++; $display("FAIL load_decode re=%0b we=%0b rd=%0d imm=%h want 1/1/7/fffffffffffffff0",
                               bus.ex_mem_re, bus.ex_reg_we, bus.ex_rd, bus.ex_imm);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] old9, want;
        old9 = m_rf[9];
`ifdef WB_BYPASS_EN
        want = 64'h55;
`else
        want = old9;
`endif
        apply(1'b0, {6'h01, 5'd10, 5'd9, 5'd0, 11'd0}, 1'b1, 5'd9, 64'h55);
        tick();
        checks++;
        if (bus.ex_rs1_data !== want) begin
            errors++; $display("FAIL same_cycle_wb got=%h want=%h", bus.ex_rs1_data, want);
        end
        apply(1'b0, {6'h01, 5'd10, 5'd9, 5'd0, 11'd0}, 1'b0, 5'd0, 64'd0);
        tick();
        checks++;
        if (bus.ex_rs1_data !== 64'h55) begin
            errors++; $display("FAIL wb_next_cycle got=%h want=55", bus.ex_rs1_data);
        end
        apply(1'b0, 32'h04000000, 1'b1, 5'd0, 64'hDEAD);
        tick();
        apply(1'b0, 32'h04000000, 1'b0, 5'd0, 64'd0);
        tick();
        checks++;
        if (bus.ex_rs1_data !== 64'd0 || bus.ex_rs2_data !== 64'd0) begin
            errors++; $display("FAIL r0_zero rs1=%h rs2=%h want 0/0", bus.ex_rs1_data, bus.ex_rs2_data);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [9];
        logic [5:0]  op;
        logic [4:0]  ra, rb;
        logic [31:0] ins;
        ops = '{6'h00, 6'h01, 6'h02, 6'h20, 6'h21, 6'h10, 6'h11, 6'h12, 6'h3F};
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            ra = 5'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom);
            ins = {op, 5'($urandom), ra, rb, 11'($urandom)};
            apply(1'b0, ins, $urandom_range(0, 1) == 1, 5'($urandom), {$urandom, $urandom});
            checks++;
            if (bus.br1 !== exp_br || (exp_br && bus.branch_target !== exp_tgt)) begin
                errors++; $display("FAIL rand_branch i=%0d br1=%0b tgt=%h want %0b/%h",
                                   i, bus.br1, bus.branch_target, exp_br, exp_tgt);
            end
            tick();
            checks++;
            if (dut_ex() !== exp_ex()) begin
                errors++; $display("FAIL rand_idex i=%0d got=%h want=%h", i, dut_ex(), exp_ex());
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 32'h0, 1'b0, 5'd0, 64'd0);
        tick();
        apply(1'b0, 32'h0, 1'b0, 5'd0, 64'd0);
        tick();
        apply(1'b0, {6'h10, 26'h0000055}, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b1 || bus.branch_target !== 9'h055) begin
            errors++; $display("FAIL mid_j_taken br1=%0b tgt=%h want 1/055", bus.br1, bus.branch_target);
        end
        tick();
        apply(1'b1, {6'h10, 26'h0000077}, 1'b0, 5'd0, 64'd0);
        checks++;
        if (bus.br1 !== 1'b0) begin
            errors++; $display("FAIL mid_rst_br1 got=%0b want=0", bus.br1);
        end
        tick();
        checks++;
        if (dut_ex() !== '0) begin
            errors++; $display("FAIL mid_rst_clear got=%h want=0", dut_ex());
        end
        apply(1'b0, 32'h04221000, 1'b0, 5'd0, 64'd0);
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_warm valid=%0b want=0", bus.ex_valid);
        end
        apply(1'b0, 32'h04221000, 1'b0, 5'd0, 64'd0);
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || dut_ex() !== exp_ex()) begin
            errors++; $display("FAIL mid_rst_resume got=%h want=%h", dut_ex(), exp_ex());
        end
    endtask

    initial begin
        bus.instr   = 32'h0;
        bus.wb_en   = 1'b0;
        bus.wb_addr = 5'd0;
        bus.wb_data = 64'd0;
        test_reset();
        test_fill();
        test_branch();
        test_load();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
